regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_wb_arbiter_arb.sv | 65 ++++++
 rtl/regfile_wb_arbiter.sv | 97 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default parameters for the register-file writeback arbiter.
//   wb_src_e    : identifies which requester produced a write (A = ALU, B = load unit)
//   arb_state_e : lock state of the round-robin arbiter
package regfile_pkg;

   localparam int unsigned DEF_WIDTH    = 64;
   localparam int unsigned DEF_ADDR_W   = 5;
   localparam int unsigned DEF_ZERO_REG = 31;

   typedef enum logic {
      SRC_A = 1'b0,
      SRC_B = 1'b1
   } wb_src_e;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCK_A   = 2'd1,
      LOCK_B   = 2'd2
   } arb_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_arb.sv
// Two-way round-robin arbiter with a grant lock for multi-beat transfers.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   a_valid, a_lock  : requester A request and keep-grant flag
//   b_valid, b_lock  : requester B request and keep-grant flag
//   gnt_c[1:0]       : combinational one-hot grant, bit 0 = A, bit 1 = B
module rr_lock_arbiter_2 (
   input  logic       clk,
   input  logic       reset,
   input  logic       a_valid,
   input  logic       a_lock,
   input  logic       b_valid,
   input  logic       b_lock,
   output logic [1:0] gnt_c
);
   import regfile_pkg::*;

   arb_state_e state_q, state_d;
   wb_src_e    ptr_q, ptr_d;

   // Grant selection and next lock state / pointer.
   always_comb begin
      gnt_c   = 2'b00;
      state_d = state_q;
      ptr_d   = ptr_q;

      case (state_q)
         LOCK_A:  gnt_c[0] = a_valid;
         LOCK_B:  gnt_c[1] = b_valid;
         default: begin
            if (a_valid && b_valid) begin
               gnt_c = (ptr_q == SRC_A) ? 2'b01 : 2'b10;
            end else begin
               gnt_c = {b_valid, a_valid};
            end
         end
      endcase

      // No beat may be accepted while the block is held in reset.
      if (reset) begin
         gnt_c = 2'b00;
      end

      // Pointer always moves to the loser side, including on lock exit.
      if (gnt_c[0]) begin
         ptr_d   = SRC_B;
         state_d = a_lock ? LOCK_A : UNLOCKED;
      end else if (gnt_c[1]) begin
         ptr_d   = SRC_A;
         state_d = b_lock ? LOCK_B : UNLOCKED;
      end
   end

   // State and pointer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= UNLOCKED;
         ptr_q   <= SRC_A;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the ALU (A) and load unit (B).
// Accepted beats are registered onto the write port one cycle later; writes
// to the hardwired-zero register are accepted but never issued.
// Ports:
//   clk, reset                          : clock, synchronous active-high reset
//   a_valid/a_ready/a_addr/a_data/a_lock: requester A handshake and payload
//   b_valid/b_ready/b_addr/b_data/b_lock: requester B handshake and payload
//   wr_en/wr_addr/wr_data               : registered register-file write port
//   wr_src                              : source of the current write (0 = A, 1 = B)
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned ZERO_REG = DEF_ZERO_REG
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [WIDTH-1:0]  a_data,
   input  logic              a_lock,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [WIDTH-1:0]  b_data,
   input  logic              b_lock,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WIDTH-1:0]  wr_data,
   output logic              wr_src
);

   logic [1:0]        gnt_c;
   logic              sel_b_c;
   logic              issue_c;
   logic [ADDR_W-1:0] sel_addr_c;
   logic [WIDTH-1:0]  sel_data_c;

   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [WIDTH-1:0]  wr_data_q, wr_data_d;
   wb_src_e           wr_src_q, wr_src_d;

   rr_lock_arbiter_2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .a_valid (a_valid),
      .a_lock  (a_lock),
      .b_valid (b_valid),
      .b_lock  (b_lock),
      .gnt_c   (gnt_c)
   );

   assign a_ready = gnt_c[0];
   assign b_ready = gnt_c[1];

   // Payload mux and zero-register filter; address/data only move on a real write.
   always_comb begin
      sel_b_c    = gnt_c[1];
      sel_addr_c = sel_b_c ? b_addr : a_addr;
      sel_data_c = sel_b_c ? b_data : a_data;
      issue_c    = (|gnt_c) && (sel_addr_c != ADDR_W'(ZERO_REG));

      wr_en_d   = issue_c;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_src_d  = wr_src_q;
      if (issue_c) begin
         wr_addr_d = sel_addr_c;
         wr_data_d = sel_data_c;
         wr_src_d  = sel_b_c ? SRC_B : SRC_A;
      end
   end

   // Write-port output register.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_src_q  <= SRC_A;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wr_src_q  <= wr_src_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign wr_src  = wr_src_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table followed by random
// traffic checked against a transaction-level model of the arbiter.
module tb_regfile_wb_arbiter;

   localparam int unsigned WIDTH  = 64;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned ZREG   = 31;

   logic              clk = 1'b0;
   logic              reset;
   logic              a_valid, a_ready, a_lock;
   logic [ADDR_W-1:0] a_addr;
   logic [WIDTH-1:0]  a_data;
   logic              b_valid, b_ready, b_lock;
   logic [ADDR_W-1:0] b_addr;
   logic [WIDTH-1:0]  b_data;
   logic              wr_en, wr_src;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(ZREG)) dut (
      .clk     (clk),
      .reset   (reset),
      .a_valid (a_valid),
      .a_ready (a_ready),
      .a_addr  (a_addr),
      .a_data  (a_data),
      .a_lock  (a_lock),
      .b_valid (b_valid),
      .b_ready (b_ready),
      .b_addr  (b_addr),
      .b_data  (b_data),
      .b_lock  (b_lock),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .wr_src  (wr_src)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d] @%0t: got %0h, expected %0h", name, idx, $time, act, exp);
      end
   endtask

   // One cycle of inputs plus the expected readies (this cycle) and write port (next cycle).
   typedef struct {
      logic              rst;
      logic              av;
      logic [ADDR_W-1:0] aa;
      logic [WIDTH-1:0]  ad;
      logic              al;
      logic              bv;
      logic [ADDR_W-1:0] ba;
      logic [WIDTH-1:0]  bd;
      logic              bl;
      logic              ar;
      logic              br;
      logic              en;
      logic [ADDR_W-1:0] wa;
      logic [WIDTH-1:0]  wd;
      logic              ws;
   } vec_t;

   function automatic vec_t mk(input int rst, input int av, input int aa, input int ad, input int al,
                               input int bv, input int ba, input int bd, input int bl,
                               input int ar, input int br, input int en, input int wa, input int wd,
                               input int ws);
      vec_t v;
      v.rst = 1'(rst); v.av = 1'(av); v.aa = ADDR_W'(aa); v.ad = WIDTH'(ad); v.al = 1'(al);
      v.bv = 1'(bv); v.ba = ADDR_W'(ba); v.bd = WIDTH'(bd); v.bl = 1'(bl);
      v.ar = 1'(ar); v.br = 1'(br); v.en = 1'(en); v.wa = ADDR_W'(wa); v.wd = WIDTH'(wd);
      v.ws = 1'(ws);
      return v;
   endfunction

   localparam int NVEC = 22;
   vec_t vecs [NVEC];

   // Transaction-level model: who holds the lock, whose turn it is, and the last issued write.
   int                m_owner;   // -1 = nobody, 0 = A, 1 = B
   int                m_turn;    // requester that wins a contested cycle
   logic              m_en;
   logic [ADDR_W-1:0] m_addr;
   logic [WIDTH-1:0]  m_data;
   logic              m_src;

   function automatic int winner();
      if (reset) return -1;
      if (m_owner == 0) return a_valid ? 0 : -1;
      if (m_owner == 1) return b_valid ? 1 : -1;
      if (a_valid && b_valid) return m_turn;
      if (a_valid) return 0;
      if (b_valid) return 1;
      return -1;
   endfunction

   task automatic model_edge(input int w);
      logic [ADDR_W-1:0] addr;
      if (reset) begin
         m_owner = -1; m_turn = 0; m_en = 1'b0;
         m_addr = '0; m_data = '0; m_src = 1'b0;
      end else if (w < 0) begin
         m_en = 1'b0;
      end else begin
         addr = (w == 0) ? a_addr : b_addr;
         m_en = (int'(addr) != int'(ZREG));
         if (m_en) begin
            m_addr = addr;
            m_data = (w == 0) ? a_data : b_data;
            m_src  = 1'(w);
         end
         m_turn  = 1 - w;
         m_owner = (((w == 0) ? a_lock : b_lock) == 1'b1) ? w : -1;
      end
   endtask

   // Pending beats for the random phase; held until accepted.
   logic              pa_v, pa_l, pb_v, pb_l;
   logic [ADDR_W-1:0] pa_a, pb_a;
   logic [WIDTH-1:0]  pa_d, pb_d;

   function automatic logic [ADDR_W-1:0] rnd_addr();
      if ($urandom_range(7) == 0) return ADDR_W'(ZREG);
      return ADDR_W'($urandom_range(31));
   endfunction

   initial begin
      int w;
      logic a_acc, b_acc;

      //          rst av aa  ad      al bv ba  bd       bl  ar br en wa wd      ws
      // Reset held with A requesting.
      vecs[0]  = mk(1, 1, 3,  10,     0, 0, 0,  0,       0,  0, 0, 0, 0,  0,      0);
      vecs[1]  = mk(1, 1, 3,  10,     0, 0, 0,  0,       0,  0, 0, 0, 0,  0,      0);
      // Both valid four cycles: A first (pointer = A after reset), then alternating.
      vecs[2]  = mk(0, 1, 1,  11,     0, 1, 2,  22,      0,  1, 0, 1, 1,  11,     0);
      vecs[3]  = mk(0, 1, 3,  33,     0, 1, 2,  22,      0,  0, 1, 1, 2,  22,     1);
      vecs[4]  = mk(0, 1, 3,  33,     0, 1, 4,  44,      0,  1, 0, 1, 3,  33,     0);
      vecs[5]  = mk(0, 1, 7,  77,     0, 1, 4,  44,      0,  0, 1, 1, 4,  44,     1);
      vecs[6]  = mk(0, 1, 7,  77,     0, 0, 0,  0,       0,  1, 0, 1, 7,  77,     0);
      vecs[7]  = mk(0, 0, 0,  0,      0, 0, 0,  0,       0,  0, 0, 0, 0,  0,      0);
      // A only, addr 3 data 10, then idle.
      vecs[8]  = mk(0, 1, 3,  10,     0, 0, 0,  0,       0,  1, 0, 1, 3,  10,     0);
      vecs[9]  = mk(0, 0, 0,  0,      0, 0, 0,  0,       0,  0, 0, 0, 0,  0,      0);
      // B locks, idles two cycles while A waits, then unlocks; A wins next.
      vecs[10] = mk(0, 1, 9,  99,     0, 1, 5,  1000000, 1,  0, 1, 1, 5,  1000000, 1);
      vecs[11] = mk(0, 1, 9,  99,     0, 0, 0,  0,       0,  0, 0, 0, 0,  0,      0);
      vecs[12] = mk(0, 1, 9,  99,     0, 0, 0,  0,       0,  0, 0, 0, 0,  0,      0);
      vecs[13] = mk(0, 1, 9,  99,     0, 1, 6,  66,      0,  0, 1, 1, 6,  66,     1);
      vecs[14] = mk(0, 1, 9,  99,     0, 1, 8,  88,      0,  1, 0, 1, 9,  99,     0);
      vecs[15] = mk(0, 0, 0,  0,      0, 1, 8,  88,      0,  0, 1, 1, 8,  88,     1);
      // Zero register accepted but not written; pointer still advances to B.
      vecs[16] = mk(0, 1, 31, 7,      0, 0, 0,  0,       0,  1, 0, 0, 0,  0,      0);
      vecs[17] = mk(0, 1, 2,  20,     1, 1, 3,  30,      0,  0, 1, 1, 3,  30,     1);
      // A takes the lock, issues another locked beat, then reset hits.
      vecs[18] = mk(0, 1, 2,  20,     1, 0, 0,  0,       0,  1, 0, 1, 2,  20,     0);
      vecs[19] = mk(0, 1, 4,  40,     1, 1, 10, 100,     0,  1, 0, 1, 4,  40,     0);
      vecs[20] = mk(1, 1, 4,  41,     1, 1, 10, 100,     0,  0, 0, 0, 0,  0,      0);
      vecs[21] = mk(0, 0, 0,  0,      0, 1, 10, 100,     0,  0, 1, 1, 10, 100,    1);

      reset = 1'b1; a_valid = 1'b0; a_addr = '0; a_data = '0; a_lock = 1'b0;
      b_valid = 1'b0; b_addr = '0; b_data = '0; b_lock = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         reset = vecs[i].rst;
         a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad; a_lock = vecs[i].al;
         b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd; b_lock = vecs[i].bl;
         #1;
         check("vec a_ready", i, 64'(a_ready), 64'(vecs[i].ar));
         check("vec b_ready", i, 64'(b_ready), 64'(vecs[i].br));
         @(posedge clk);
         #1;
         check("vec wr_en", i, 64'(wr_en), 64'(vecs[i].en));
         if (vecs[i].en || vecs[i].rst) begin
            check("vec wr_addr", i, 64'(wr_addr), 64'(vecs[i].wa));
            check("vec wr_data", i, 64'(wr_data), 64'(vecs[i].wd));
            check("vec wr_src",  i, 64'(wr_src),  64'(vecs[i].ws));
         end
      end

      // Random traffic against the model, with occasional mid-stream resets.
      pa_v = 1'b0; pb_v = 1'b0; a_acc = 1'b0; b_acc = 1'b0;
      pa_l = 1'b0; pb_l = 1'b0; pa_a = '0; pb_a = '0; pa_d = '0; pb_d = '0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         reset = (c < 2) || ($urandom_range(49) == 0);
         if (!pa_v || a_acc) begin
            pa_v = ($urandom_range(3) != 0);
            pa_a = rnd_addr();
            pa_d = {$urandom, $urandom};
            pa_l = ($urandom_range(2) == 0);
         end
         if (!pb_v || b_acc) begin
            pb_v = ($urandom_range(3) != 0);
            pb_a = rnd_addr();
            pb_d = {$urandom, $urandom};
            pb_l = ($urandom_range(2) == 0);
         end
         a_valid = pa_v; a_addr = pa_a; a_data = pa_d; a_lock = pa_l;
         b_valid = pb_v; b_addr = pb_a; b_data = pb_d; b_lock = pb_l;
         #1;
         w = winner();
         a_acc = (w == 0);
         b_acc = (w == 1);
         check("rnd a_ready", c, 64'(a_ready), 64'(a_acc));
         check("rnd b_ready", c, 64'(b_ready), 64'(b_acc));
         @(posedge clk);
         model_edge(w);
         #1;
         check("rnd wr_en", c, 64'(wr_en), 64'(m_en));
         if (m_en || reset) begin
            check("rnd wr_addr", c, 64'(wr_addr), 64'(m_addr));
            check("rnd wr_data", c, 64'(wr_data), 64'(m_data));
            check("rnd wr_src",  c, 64'(wr_src),  64'(m_src));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
